// File: rtl/gate_pkg.sv
// Shared definitions for the gate-op scheduler: op codes, FSM states, defaults.
package gate_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 8;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NOT  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise gate unit; reserved op yields zero with err set.
module gate_alu
   import gate_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one gate_alu among NREQ requesters.
// One transaction in flight: IDLE (arbitrate) -> EXEC (compute) -> HOLD (deliver).
module gate_op_scheduler
   import gate_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   parameter  int W    = DEF_W,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] op_in,
   input  logic [W*NREQ-1:0] a_in,
   input  logic [W*NREQ-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDW-1:0]    res_id,
   output logic [W-1:0]      res_data,
   output logic              res_err
);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic [IDW-1:0] cand;
   logic           found;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   alu_y;
   logic           alu_err;

   // First requesting index at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         gnt       <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         gnt <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt    <= NREQ'(1) << win;
                  res_id <= win;
                  ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_data  <= alu_y;
               res_err   <= alu_err;
               res_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Operand capture is pure data; it is only ever consumed in EXEC after a grant.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && found) begin
         op_q <= op_in[3*win +: 3];
         a_q  <= a_in[W*win +: W];
         b_q  <= b_in[W*win +: W];
      end
   end

   gate_alu #(.W(W)) u_alu (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .y   (alu_y),
      .err (alu_err)
   );

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed bench for gate_op_scheduler with a transaction-level reference model.
module tb_gate_op_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [11:0] op_in = '0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        res_ready = 1'b1;
   logic [3:0]  gnt;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [7:0]  res_data;
   logic        res_err;

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;
   int glog[$];

   gate_op_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_in     (op_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_data  (res_data),
      .res_err   (res_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] gate_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, ~a};
         3'd3:    return {1'b0, ~(a & b)};
         3'd4:    return {1'b0, ~(a | b)};
         3'd5:    return {1'b0, a ^ b};
         3'd6:    return {1'b0, ~(a ^ b)};
         default: return {1'b1, 8'h00};
      endcase
   endfunction

   // Reference: a grant opens a transaction whose result is offered one cycle
   // later and retired by the first accepted handshake.
   int         m_phase;
   int         m_ptr;
   int         m_w;
   logic [1:0] m_c;
   logic [3:0] m_gnt;
   logic       m_valid;
   logic [1:0] m_id;
   logic [7:0] m_data;
   logic       m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_ptr   = 0;
         m_gnt   = '0;
         m_valid = 1'b0;
         m_id    = '0;
         m_data  = '0;
         m_err   = 1'b0;
      end else begin
         m_gnt = '0;
         if (m_phase == 0) begin
            if (req != 4'b0) begin
               m_w = -1;
               for (int k = 0; k < NREQ; k++) begin
                  m_c = 2'((m_ptr + k) % NREQ);
                  if (m_w < 0 && req[m_c]) m_w = int'(m_c);
               end
               m_gnt = 4'b0001 << m_w;
               m_id  = 2'(m_w);
               {m_err, m_data} = gate_model(op_in[3*m_w +: 3], a_in[8*m_w +: 8], b_in[8*m_w +: 8]);
               m_ptr   = (m_w + 1) % NREQ;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_valid = 1'b1;
            m_phase = 2;
         end else if (res_ready) begin
            m_valid = 1'b0;
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("gnt_vs_model", 32'(gnt), 32'(m_gnt));
         check("valid_vs_model", 32'(res_valid), 32'(m_valid));
         if (m_valid) begin
            check("id_vs_model", 32'(res_id), 32'(m_id));
            check("data_vs_model", 32'(res_data), 32'(m_data));
            check("err_vs_model", 32'(res_err), 32'(m_err));
         end
         for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
      end
   end

   task automatic run_one(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [3:0] g, output logic [7:0] d, output logic e, output logic [1:0] id);
      logic ok;
      op_in[3*idx +: 3] = op;
      a_in[8*idx +: 8]  = a;
      b_in[8*idx +: 8]  = b;
      req = 4'b0001 << idx;
      ok = 1'b0;
      g  = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (gnt != 4'b0) begin ok = 1'b1; g = gnt; end
      end
      check("gnt_timeout", 32'(ok), 32'd1);
      req = '0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (res_valid) ok = 1'b1;
      end
      check("valid_timeout", 32'(ok), 32'd1);
      d  = res_data;
      e  = res_err;
      id = res_id;
   endtask

   logic [7:0] exp_d [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

   initial begin
      logic [3:0] g;
      logic [7:0] d;
      logic [7:0] snap;
      logic       e;
      logic       ok;
      logic [1:0] id;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_data", 32'(res_data), 32'd0);
      check("rst_err", 32'(res_err), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      run_one(0, 3'd0, 8'hF0, 8'h3C, g, d, e, id);
      check("basic_gnt", 32'(g), 32'h1);
      check("basic_data", 32'(d), 32'h30);
      check("basic_id", 32'(id), 32'd0);
      check("basic_err", 32'(e), 32'd0);

      for (int op = 0; op < 8; op++) begin
         run_one(3, 3'(op), 8'hA5, 8'h0F, g, d, e, id);
         check("op_gnt", 32'(g), 32'h8);
         check("op_data", 32'(d), 32'(exp_d[op]));
         check("op_err", 32'(e), (op == 7) ? 32'd1 : 32'd0);
      end

      for (int i = 0; i < NREQ; i++) begin
         op_in[3*i +: 3] = 3'd5;
         a_in[8*i +: 8]  = 8'(8'h11 * (i + 1));
         b_in[8*i +: 8]  = 8'h0F;
      end
      glog.delete();
      @(negedge clk);
      req = 4'hF;
      for (int c = 0; c < 100 && glog.size() < 8; c++) begin
         @(negedge clk);
         #1;
      end
      req = '0;
      check("rr_grant_count", 32'(glog.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < glog.size()) check("rr_order", 32'(glog[i]), 32'(i % 4));
      end
      repeat (4) @(negedge clk);

      res_ready = 1'b0;
      op_in[6 +: 3] = 3'd1;
      a_in[16 +: 8] = 8'h3C;
      b_in[16 +: 8] = 8'hC3;
      req = 4'b0100;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (gnt == 4'b0100) ok = 1'b1;
      end
      check("bp_first_gnt", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (res_valid) ok = 1'b1;
      end
      check("bp_valid", 32'(ok), 32'd1);
      snap = res_data;
      check("bp_data", 32'(snap), 32'hFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_stable", 32'(res_data), 32'(snap));
         check("bp_no_gnt", 32'(gnt), 32'd0);
      end
      res_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2 && !ok; i++) begin
         @(negedge clk);
         if (gnt == 4'b0100) ok = 1'b1;
      end
      check("bp_regrant", 32'(ok), 32'd1);
      req = '0;
      repeat (4) @(negedge clk);

      req = 4'b0010;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (gnt != 4'b0) ok = 1'b1;
      end
      check("mid_gnt", 32'(ok), 32'd1);
      req = '0;
      #2 rst = 1'b1;
      #1;
      check("async_gnt", 32'(gnt), 32'd0);
      check("async_valid", 32'(res_valid), 32'd0);
      check("async_id", 32'(res_id), 32'd0);
      check("async_data", 32'(res_data), 32'd0);
      check("async_err", 32'(res_err), 32'd0);
      req = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_valid", 32'(res_valid), 32'd0);
      req = '0;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_op_scheduler.md
GATE_OP_SCHEDULER -- requirements
Module: gate_op_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the gate unit.
REQ-002 Parameter W, default 8, operand and result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester request level; held until that requester's gnt.
REQ-006 op_in  input  3*NREQ  packed op codes, requester i in bits [3i+2:3i].
REQ-007 a_in  input  W*NREQ  packed operand A, requester i in bits [W*i+W-1:W*i].
REQ-008 b_in  input  W*NREQ  packed operand B, same packing as a_in.
REQ-009 gnt  output  NREQ  one-hot, registered grant pulse, one cycle.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result when res_valid and res_ready are both high.
REQ-012 res_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-013 res_data  output  W  bitwise gate result.
REQ-014 res_err  output  1  the op code was reserved.

Function
REQ-015 Op codes: 0 AND, 1 OR, 2 NOT (of A; B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-016 A reserved op SHALL produce res_data=0 with res_err=1; res_err=0 for all other ops.
REQ-017 FSM states SHALL be IDLE, EXEC and HOLD.
REQ-018 IDLE->EXEC on any req bit high; the same edge captures the winner's op, A, B and index, and raises gnt for exactly one cycle.
REQ-019 EXEC->HOLD unconditionally; the edge registers the gate-unit output into res_data and res_err.
REQ-020 res_valid SHALL be 1 exactly while in HOLD.
REQ-021 res_data, res_id and res_err SHALL stay stable in HOLD.
REQ-022 HOLD->IDLE on res_ready=1; otherwise stay in HOLD (backpressure, unbounded).
REQ-023 Latency: gnt high in cycle T+1 and res_valid high from cycle T+2, where T is the IDLE cycle that sees req.
REQ-024 Minimum spacing between grants is 3 cycles.
REQ-025 Arbitration SHALL be round-robin: search starts at pointer ptr, and ptr becomes winner+1 mod NREQ on each grant.
REQ-026 req changes while in EXEC or HOLD SHALL be ignored; arbitration samples req only in IDLE.
REQ-027 A requester that drops req before grant is not served; no request is queued.
REQ-028 Simultaneous requests SHALL yield exactly one gnt bit.
REQ-029 Results SHALL be delivered in grant order.

Reset
REQ-030 rst=1 asynchronously forces state=IDLE, ptr=0, gnt=0, res_valid=0, res_id=0, res_data=0 and res_err=0.
REQ-031 Reset mid-operation (EXEC or HOLD) SHALL discard the in-flight result, with no res_valid after release.
REQ-032 The first IDLE cycle after rst deasserts SHALL be arbitration-eligible.

Structure
REQ-033 Shared package gate_pkg SHALL hold the op code constants, FSM state encodings and the default NREQ/W.
REQ-034 The combinational bitwise unit SHALL be the single sub-module gate_alu (inputs op, a, b; outputs y, err), instantiated once.
REQ-035 Arbiter, operand capture registers and FSM SHALL reside in gate_op_scheduler.

Verification
REQ-036 Reset, then req=0001 with op 0, a=8'hF0, b=8'h3C and res_ready=1 -> gnt=0001 one cycle, then res_valid=1 with res_data=8'h30, res_id=0, res_err=0.
REQ-037 All ops 0..6 with a=8'hA5, b=8'h0F -> res_data 05, AF, 5A, FA, 50, AA, 55; op 7 -> res_data=00 with res_err=1.
REQ-038 req=1111 held for 8 grants -> grant order 0,1,2,3,0,1,2,3, with each res_id matching the preceding grant.
REQ-039 res_ready=0 for 5 cycles in HOLD while req=0100 -> res_data stable and no gnt; after res_ready=1, gnt=0100 appears within 2 cycles.
REQ-040 Assert rst during EXEC -> all outputs 0 immediately with no clock edge; after release no stale res_valid, and ptr=0 (req=1111 grants requester 0).
